// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a valid/ready byte stream little-endian into 32-bit words,
// writes them from address 0 and holds the CPU in reset until the load is complete.
// Optional build macro IMEM_LOADER_CHECKSUM_EN enables the running mod-256 byte checksum.
module imem_loader #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned MEM_BYTES     = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [7:0]               s_data,
  input  logic                     s_last,
  input  logic                     start,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     cpu_rst,
  output logic                     done,
  output logic                     error,
  output logic [ADDRESS_WIDTH-2:0] word_count,
  output logic [7:0]               checksum
);

  // One spare address bit so a full 2**ADDRESS_WIDTH memory can still be compared against.
  localparam int unsigned ADDR_INT_W = ADDRESS_WIDTH + 1;
  localparam int unsigned WC_W       = ADDRESS_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t                  r_state,      w_state;
  logic [1:0]              r_idx,        w_idx;
  logic [DATA_WIDTH-1:0]   r_word,       w_word;
  logic                    r_last,       w_last;
  logic [ADDR_INT_W-1:0]   r_addr,       w_addr;
  logic [WC_W-1:0]         r_word_count, w_word_count;
  logic [DATA_WIDTH-1:0]   r_mem_wdata,  w_mem_wdata;
  logic                    r_s_ready,    w_s_ready;
  logic                    r_mem_we,     w_mem_we;
  logic                    r_cpu_rst,    w_cpu_rst;
  logic                    r_done,       w_done;
  logic                    r_error,      w_error;
  logic [DATA_WIDTH-1:0]   w_packed;
  logic                    w_accept;
  logic                    w_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]              r_sum,        w_sum;
`endif

  assign w_accept = s_valid && r_s_ready;
  assign w_full   = (r_idx == 2'd0) && (r_addr == ADDR_INT_W'(MEM_BYTES));

  // Byte 0 starts a fresh word, so unfilled upper bytes of a short final word read as zero.
  always_comb begin
    w_packed = (r_idx == 2'd0) ? '0 : r_word;
    w_packed[{r_idx, 3'b000} +: 8] = s_data;
  end

  // Next-state and next-output logic; all outputs are registered from these values.
  always_comb begin
    w_state      = r_state;
    w_idx        = r_idx;
    w_word       = r_word;
    w_last       = r_last;
    w_addr       = r_addr;
    w_word_count = r_word_count;
    w_mem_wdata  = r_mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    w_sum        = r_sum;
`endif

    case (r_state)
      ST_LOAD: begin
        if (w_accept) begin
          if (w_full) begin
            w_state = ST_ERROR;
          end else begin
            w_word = w_packed;
            w_idx  = r_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_sum  = r_sum + s_data;
`endif
            if ((r_idx == 2'd3) || s_last) begin
              w_state     = ST_WRITE;
              w_mem_wdata = w_packed;
              w_last      = s_last;
              w_idx       = 2'd0;
            end
          end
        end
      end
      ST_WRITE: begin
        w_addr       = r_addr + ADDR_INT_W'(4);
        w_word_count = r_word_count + WC_W'(1);
        w_state      = r_last ? ST_DONE : ST_LOAD;
      end
      ST_DONE, ST_ERROR: begin
        if (start) begin
          w_state      = ST_LOAD;
          w_addr       = '0;
          w_word_count = '0;
          w_idx        = 2'd0;
          w_last       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_sum        = 8'h00;
`endif
        end
      end
      default: w_state = ST_LOAD;
    endcase

    w_s_ready = (w_state == ST_LOAD);
    w_mem_we  = (w_state == ST_WRITE);
    w_cpu_rst = (w_state != ST_DONE);
    w_done    = (w_state == ST_DONE);
    w_error   = (w_state == ST_ERROR);
  end

  // State and output registers; reset drops any partially assembled word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_LOAD;
      r_idx        <= 2'd0;
      r_word       <= '0;
      r_last       <= 1'b0;
      r_addr       <= '0;
      r_word_count <= '0;
      r_mem_wdata  <= '0;
      r_s_ready    <= 1'b1;
      r_mem_we     <= 1'b0;
      r_cpu_rst    <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum        <= 8'h00;
`endif
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_word       <= w_word;
      r_last       <= w_last;
      r_addr       <= w_addr;
      r_word_count <= w_word_count;
      r_mem_wdata  <= w_mem_wdata;
      r_s_ready    <= w_s_ready;
      r_mem_we     <= w_mem_we;
      r_cpu_rst    <= w_cpu_rst;
      r_done       <= w_done;
      r_error      <= w_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum        <= w_sum;
`endif
    end
  end

  assign s_ready    = r_s_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_addr[ADDRESS_WIDTH-1:0];
  assign mem_wdata  = r_mem_wdata;
  assign cpu_rst    = r_cpu_rst;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign checksum   = r_sum;
`else
  assign checksum   = 8'h00;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (MEM_BYTES=8): a byte-queue reference model checked every cycle,
// plus hand-computed write lists and flag values for each directed program.
module tb_imem_loader;

  localparam int unsigned AW   = 16;
  localparam int unsigned MEMB = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  localparam int P_LOAD  = 0;
  localparam int P_WRITE = 1;
  localparam int P_DONE  = 2;
  localparam int P_ERROR = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = 8'h00;
  logic          s_last = 1'b0;
  logic          start = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          error;
  logic [AW-2:0] word_count;
  logic [7:0]    checksum;

  int checks = 0;
  int errors = 0;

  imem_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(AW), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .error(error),
    .word_count(word_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Reference model: pending bytes of the current word, words written, phase of the load.
  int          m_phase = P_LOAD;
  logic [7:0]  m_bytes[$];
  int          m_words = 0;
  logic [7:0]  m_sum = 8'h00;
  logic [31:0] m_wdata = 32'h0;
  bit          m_lastw = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_LOAD;
      m_bytes.delete();
      m_words = 0;
      m_sum   = 8'h00;
    end else begin
      case (m_phase)
        P_LOAD: if (s_valid) begin
          if (m_bytes.size() == 0 && m_words * 4 == int'(MEMB)) begin
            m_phase = P_ERROR;
          end else begin
            m_bytes.push_back(s_data);
            m_sum = m_sum + s_data;
            if (m_bytes.size() == 4 || s_last) begin
              m_wdata = 32'h0;
              foreach (m_bytes[k]) m_wdata = m_wdata | (32'(m_bytes[k]) << (8 * k));
              m_lastw = s_last;
              m_phase = P_WRITE;
            end
          end
        end
        P_WRITE: begin
          m_words++;
          m_bytes.delete();
          m_phase = m_lastw ? P_DONE : P_LOAD;
        end
        default: if (start) begin
          m_words = 0;
          m_sum   = 8'h00;
          m_bytes.delete();
          m_phase = P_LOAD;
        end
      endcase
    end
  end

  logic [15:0] got_a[$];
  logic [31:0] got_d[$];
  logic [15:0] exp_a[$];
  logic [31:0] exp_d[$];

  // Per-cycle comparison against the model, and capture of every write seen on the port.
  always @(negedge clk) begin
    chk("s_ready",    32'(s_ready),    32'(m_phase == P_LOAD));
    chk("mem_we",     32'(mem_we),     32'(m_phase == P_WRITE));
    chk("cpu_rst",    32'(cpu_rst),    32'(m_phase != P_DONE));
    chk("done",       32'(done),       32'(m_phase == P_DONE));
    chk("error",      32'(error),      32'(m_phase == P_ERROR));
    chk("mem_addr",   32'(mem_addr),   32'(m_words * 4));
    chk("word_count", 32'(word_count), 32'(m_words));
    chk("checksum",   32'(checksum),   CK_EN ? 32'(m_sum) : 32'h0);
    if (m_phase == P_WRITE) chk("mem_wdata", mem_wdata, m_wdata);
    if (mem_we === 1'b1) begin
      got_a.push_back(mem_addr);
      got_d.push_back(mem_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (s_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready %b after %0d cycles, required 1", s_ready, n);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic offer_byte(input logic [7:0] d);
    s_valid = 1'b1;
    s_data  = d;
    repeat (2) @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic new_test();
    got_a.delete(); got_d.delete();
    exp_a.delete(); exp_d.delete();
  endtask

  task automatic check_writes(input string name);
    chk({name, "_nwrites"}, 32'(got_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      chk({name, "_addr"}, 32'(got_a[i]), 32'(exp_a[i]));
      chk({name, "_data"}, got_d[i], exp_d[i]);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(s_ready), 32'h1);
    chk("rst_cpu",   32'(cpu_rst), 32'h1);
    chk("rst_addr",  32'(mem_addr), 32'h0);
    rst = 1'b0;

    // 1: single full word terminated by s_last
    new_test();
    exp_a.push_back(16'h0); exp_d.push_back(32'h00000513);
    send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'h00, 1);
    chk("t1_we", 32'(mem_we), 32'h1);
    @(negedge clk);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_cpu",  32'(cpu_rst), 32'h0);
    chk("t1_wc",   32'(word_count), 32'h1);
    @(negedge clk);
    check_writes("t1");

    // 2: two full words
    pulse_start();
    new_test();
    exp_a.push_back(16'h0); exp_d.push_back(32'h00100293);
    exp_a.push_back(16'h4); exp_d.push_back(32'h00200313);
    send_byte(8'h93, 0); send_byte(8'h02, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h03, 0); send_byte(8'h20, 0); send_byte(8'h00, 1);
    repeat (2) @(negedge clk);
    chk("t2_wc", 32'(word_count), 32'h2);
    check_writes("t2");

    // 3: second word partial, zero-padded
    pulse_start();
    new_test();
    exp_a.push_back(16'h0); exp_d.push_back(32'hDDCCBBAA);
    exp_a.push_back(16'h4); exp_d.push_back(32'h00002211);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 1);
    repeat (2) @(negedge clk);
    check_writes("t3");

    // 4: overflow past an 8-byte memory
    pulse_start();
    new_test();
    exp_a.push_back(16'h0); exp_d.push_back(32'h14131211);
    exp_a.push_back(16'h4); exp_d.push_back(32'h18171615);
    for (int i = 0; i < 9; i++) send_byte(8'(8'h11 + i), 0);
    for (int i = 9; i < 12; i++) offer_byte(8'(8'h11 + i));
    chk("t4_error", 32'(error), 32'h1);
    chk("t4_ready", 32'(s_ready), 32'h0);
    chk("t4_cpu",   32'(cpu_rst), 32'h1);
    check_writes("t4");

    // 5: reset mid-word discards the partial word
    pulse_start();
    new_test();
    exp_a.push_back(16'h0); exp_d.push_back(32'h04030201);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 1);
    repeat (2) @(negedge clk);
    check_writes("t5");

    // 6: checksum, restart, reload from address 0
    pulse_start();
    new_test();
    exp_a.push_back(16'h0); exp_d.push_back(32'h201001FF);
    exp_a.push_back(16'h0); exp_d.push_back(32'h201001FF);
    send_byte(8'hFF, 0); send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h20, 1);
    repeat (2) @(negedge clk);
    chk("t6_sum", 32'(checksum), CK_EN ? 32'h30 : 32'h0);
    pulse_start();
    chk("t6_sum_clr", 32'(checksum), 32'h0);
    chk("t6_cpu",     32'(cpu_rst), 32'h1);
    chk("t6_done",    32'(done), 32'h0);
    chk("t6_wc",      32'(word_count), 32'h0);
    send_byte(8'hFF, 0); send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h20, 1);
    repeat (2) @(negedge clk);
    check_writes("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
